// File: rtl/layer_4_input_packer.sv
// Channel-serial to channel-parallel packer for the layer-4 convolution blocks.
// Collects NUM_CH channel beats per pixel and emits one wide word per pixel, frame by frame.
module layer_4_input_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 32,
  parameter int IMG_SIZE   = 104
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         start,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         valid_in,
  output logic                         ready_in,
  output logic [DATA_WIDTH*NUM_CH-1:0] data_out,
  output logic                         valid_out,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int POS_W = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(IMG_SIZE - 1);

  typedef enum logic [1:0] {IDLE, PACK, DONE} state_t;

  state_t                       state;
  logic [CH_W-1:0]              ch_cnt;
  logic [POS_W-1:0]             col_cnt;
  logic [POS_W-1:0]             row_cnt;
  logic [DATA_WIDTH-1:0]        slot_q [NUM_CH];
  logic [DATA_WIDTH*NUM_CH-1:0] packed_word;
  logic                         accept;

  assign accept = valid_in && ready_in;

  // NOTE: the assembly buffer is deliberately left without reset; its contents
  // only reach data_out once every slot of a pixel has been rewritten.
  always_ff @(posedge Clk) begin
    if (accept) slot_q[ch_cnt] <= data_in;
  end

  // The last channel bypasses the buffer so the word is complete on the beat itself.
  always_comb begin
    packed_word = '0;
    for (int k = 0; k < NUM_CH - 1; k++) begin
      packed_word[DATA_WIDTH*k +: DATA_WIDTH] = slot_q[k];
    end
    packed_word[DATA_WIDTH*(NUM_CH-1) +: DATA_WIDTH] = data_in;
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= IDLE;
      ready_in   <= 1'b0;
      busy       <= 1'b0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      data_out   <= '0;
      ch_cnt     <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= PACK;
            ready_in <= 1'b1;
            busy     <= 1'b1;
            ch_cnt   <= '0;
            col_cnt  <= '0;
            row_cnt  <= '0;
          end
        end
        PACK: begin
          if (accept) begin
            if (ch_cnt == LAST_CH) begin
              ch_cnt    <= '0;
              data_out  <= packed_word;
              valid_out <= 1'b1;
              if (col_cnt == LAST_POS) begin
                col_cnt <= '0;
                if (row_cnt == LAST_POS) begin
                  row_cnt    <= '0;
                  state      <= DONE;
                  ready_in   <= 1'b0;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                end else begin
                  row_cnt <= row_cnt + 1'b1;
                end
              end else begin
                col_cnt <= col_cnt + 1'b1;
              end
            end else begin
              ch_cnt <= ch_cnt + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          ready_in <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_4_input_packer.sv
// Directed bench for layer_4_input_packer on a 4x4 frame of 32-channel pixels.
// Expected words are built from the per-beat stimulus pattern (slot k = base + k).
module tb_layer_4_input_packer;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          start;
  logic [31:0]   data_in;
  logic          valid_in;
  logic          ready_in;
  logic [1023:0] data_out;
  logic          valid_out;
  logic          busy;
  logic          frame_done;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int vo_cnt   = 0;

  layer_4_input_packer #(.DATA_WIDTH(32), .NUM_CH(32), .IMG_SIZE(4)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .data_in(data_in), .valid_in(valid_in),
    .ready_in(ready_in), .data_out(data_out), .valid_out(valid_out),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(negedge Clk) if (valid_out === 1'b1) vo_cnt <= vo_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required $finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [1023:0] exp_word(input logic [31:0] base);
    logic [1023:0] w;
    for (int k = 0; k < 32; k++) w[32*k +: 32] = base + 32'(k);
    return w;
  endfunction

  // Returns one step after the last beat's edge, with valid_in still high.
  task automatic send_pixel(input logic [31:0] base, input bit gapped, input int start_at);
    for (int k = 0; k < 32; k++) begin
      if (gapped && k > 0) begin
        valid_in = 1'b0;
        data_in  = 32'hbad00000 | 32'(k);
        start    = 1'b0;
        step();
      end
      data_in  = base + 32'(k);
      valid_in = 1'b1;
      start    = (k == start_at);
      step();
    end
    start = 1'b0;
  endtask

  initial begin
    int saved;
    int prev;
    logic [31:0] base;

    // Reset with a beat presented and no start
    Rst = 1'b1; start = 1'b0; valid_in = 1'b1; data_in = 32'h3f800000;
    repeat (5) step();
    check("rst_ready",  ready_in,   0);
    check("rst_data",   data_out,   0);
    check("rst_valid",  valid_out,  0);
    check("rst_busy",   busy,       0);
    check("rst_done",   frame_done, 0);
    Rst = 1'b0;
    repeat (3) step();
    check("idle_ready", ready_in, 0);
    check("idle_vo",    vo_cnt,   0);
    valid_in = 1'b0;
    step();

    // Single pixel, full rate
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_busy",  busy,     1);
    check("start_ready", ready_in, 1);
    send_pixel(32'h3c000000, 1'b0, -1);
    valid_in = 1'b0;
    check("px_valid",    valid_out,         1);
    check("px_lo",       data_out[31:0],    32'h3c000000);
    check("px_hi",       data_out[1023:992], 32'h3c00001f);
    check("px_word",     data_out,          exp_word(32'h3c000000));
    check("px_done",     frame_done,        0);
    check("px_no_early", vo_cnt,            0);
    step();
    check("px_pulse_end", valid_out, 0);
    check("px_hold",      data_out,  exp_word(32'h3c000000));
    repeat (2) step();

    // Same pixel with every other cycle idle and junk on the bus
    send_pixel(32'h3c000000, 1'b1, -1);
    valid_in = 1'b0;
    check("gap_valid", valid_out, 1);
    check("gap_word",  data_out,  exp_word(32'h3c000000));
    check("gap_vo",    vo_cnt,    1);
    step();

    // Reset after 10 beats of a pixel
    for (int k = 0; k < 10; k++) begin
      data_in = 32'h11110000 + 32'(k); valid_in = 1'b1;
      step();
    end
    #2 Rst = 1'b1;
    #1;
    check("mid_rst_data",  data_out, 0);
    check("mid_rst_ready", ready_in, 0);
    check("mid_rst_busy",  busy,     0);
    valid_in = 1'b0;
    step();
    Rst = 1'b0;
    saved = vo_cnt;
    step();
    check("mid_rst_needs_start", ready_in, 0);
    start = 1'b1;
    step();
    start = 1'b0;

    // Full 4x4 frame, continuous; first pixel carries NaN patterns, last carries denormals
    send_pixel(32'h7fc00000, 1'b0, -1);
    check("frm0_valid", valid_out, 1);
    check("frm0_word",  data_out,  exp_word(32'h7fc00000));
    check("frm0_no_stale_vo", vo_cnt, saved);
    check("frm0_done",  frame_done, 0);
    prev = cyc;
    for (int p = 1; p < 16; p++) begin
      base = (p == 15) ? 32'h00000001 : 32'h41000000 + 32'(p << 8);
      send_pixel(base, 1'b0, -1);
      check($sformatf("frm%0d_valid", p),   valid_out,  1);
      check($sformatf("frm%0d_word", p),    data_out,   exp_word(base));
      check($sformatf("frm%0d_done", p),    frame_done, (p == 15) ? 1 : 0);
      check($sformatf("frm%0d_spacing", p), cyc - prev, 32);
      prev = cyc;
    end
    check("end_ready", ready_in, 0);
    check("end_busy",  busy,     0);

    // Extra beats after the frame are ignored
    data_in = 32'h55555555;
    step();
    check("frame_pulses", vo_cnt - saved, 16);
    saved = vo_cnt;
    for (int k = 0; k < 40; k++) begin
      data_in = 32'h60000000 + 32'(k);
      step();
    end
    check("extra_vo",    vo_cnt,   saved);
    check("extra_ready", ready_in, 0);
    check("extra_hold",  data_out, exp_word(32'h00000001));

    // Restart from DONE with a coincident beat, then a start pulse mid-pixel
    start = 1'b1; valid_in = 1'b1; data_in = 32'hdeadbeef;
    step();
    start = 1'b0;
    check("restart_busy",  busy,     1);
    check("restart_ready", ready_in, 1);
    send_pixel(32'h3f000000, 1'b0, 5);
    valid_in = 1'b0;
    check("restart_valid", valid_out,  1);
    check("restart_word",  data_out,   exp_word(32'h3f000000));
    check("restart_done",  frame_done, 0);
    check("restart_busy2", busy,       1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
